binary_to_bitstream: RTL and testbench

BINARY_TO_BITSTREAM -- requirements
Module: binary_to_bitstream

---
 rtl/binary_to_bitstream_pkg.sv | 20 ++
 rtl/binary_to_bitstream_lfsr16.sv | 32 +++
 rtl/binary_to_bitstream.sv | 106 ++++++++++
 tb/tb_binary_to_bitstream.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/binary_to_bitstream_pkg.sv
// Shared types and constants for the stochastic bitstream generator.
// The full-scale constant is also used by the downstream converter.
package binary_to_bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GEN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    localparam logic [15:0] FULL_SCALE   = 16'hFFFF;

    // Right-shifting Galois step, x^16+x^14+x^13+x^11+1
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
    endfunction

endpackage

// File: rtl/binary_to_bitstream_lfsr16.sv
// 16-bit Galois LFSR with loadable state.
// A load and an advance on the same edge step from the loaded value.
module lfsr16
    import binary_to_bitstream_pkg::*;
#(
    parameter logic [15:0] SEED = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        advance,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] state
);

    logic [15:0] base;

    always_comb begin
        base = load ? load_value : state;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else if (advance) begin
            state <= lfsr_step(base);
        end else if (load) begin
            state <= base;
        end
    end

endmodule

// File: rtl/binary_to_bitstream.sv
// Converts a 16-bit probability into a fixed-length stochastic bitstream
// by comparing it against a free-running LFSR.
module binary_to_bitstream
    import binary_to_bitstream_pkg::*;
#(
    parameter int unsigned BITSTREAM_LENGTH = 1024,
    parameter logic [15:0] LFSR_SEED        = DEFAULT_SEED
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_generation,
    input  logic [15:0] binary_value,
    input  logic        seed_load,
    input  logic [15:0] seed_value,
    output logic        bitstream,
    output logic        bit_valid,
    output logic        busy,
    output logic        generation_done
);

    localparam logic [15:0] LEN = BITSTREAM_LENGTH[15:0];

    state_t      state_q;
    state_t      state_d;
    logic [15:0] cnt_q;
    logic [15:0] cnt_d;
    logic [15:0] value_q;
    logic [15:0] value_d;
    logic [15:0] lfsr;
    logic [15:0] lfsr_eff;
    logic [15:0] seed_eff;
    logic        load;
    logic        emit;
    logic        bit_d;
    logic        done_d;

    lfsr16 #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (emit),
        .load      (load),
        .load_value(seed_eff),
        .state     (lfsr)
    );

    // cnt_q holds the number of bits already emitted in this stream
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        value_d  = value_q;
        emit     = 1'b0;
        done_d   = 1'b0;
        load     = (state_q == IDLE) && seed_load;
        seed_eff = (seed_value == 16'h0000) ? LFSR_SEED : seed_value;
        lfsr_eff = load ? seed_eff : lfsr;
        unique case (state_q)
            IDLE: begin
                if (start_generation) begin
                    state_d = GEN;
                    value_d = binary_value;
                    cnt_d   = 16'd1;
                    emit    = 1'b1;
                end
            end
            GEN: begin
                if (cnt_q == LEN) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                    emit  = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        bit_d = emit && ((value_d == FULL_SCALE) || (lfsr_eff < value_d));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            cnt_q           <= 16'd0;
            value_q         <= 16'd0;
            bitstream       <= 1'b0;
            bit_valid       <= 1'b0;
            generation_done <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            value_q         <= value_d;
            bitstream       <= bit_d;
            bit_valid       <= emit;
            generation_done <= done_d;
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_binary_to_bitstream.sv
// Self-checking bench for binary_to_bitstream.
// Table-driven streams plus hand sequences for seeding and mid-stream reset.
module tb_binary_to_bitstream;

    localparam int LEN = 1024;

    typedef struct {
        logic        ld;
        logic [15:0] sd;
        logic [15:0] val;
        int          lo;
        int          hi;
        bit          hold;
        int          pulse;
        bit          chk;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_generation;
    logic [15:0] binary_value;
    logic        seed_load;
    logic [15:0] seed_value;
    logic        bitstream;
    logic        bit_valid;
    logic        busy;
    logic        generation_done;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] m;
    vec_t        tbl[6];

    binary_to_bitstream #(
        .BITSTREAM_LENGTH(LEN),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start_generation(start_generation),
        .binary_value    (binary_value),
        .seed_load       (seed_load),
        .seed_value      (seed_value),
        .bitstream       (bitstream),
        .bit_valid       (bit_valid),
        .busy            (busy),
        .generation_done (generation_done)
    );

    always #5 clk = ~clk;

    // Reference LFSR written from the polynomial taps 16,14,13,11
    function automatic logic [15:0] model_step(input logic [15:0] s);
        logic [15:0] n;
        n = {1'b0, s[15:1]};
        if (s[0]) begin
            n[15] = 1'b1;
            n[13] = ~n[13];
            n[12] = ~n[12];
            n[10] = ~n[10];
        end
        return n;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act,
                           input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d want %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Called at a negedge with the DUT in IDLE; returns at the negedge
    // after the stream, with the DUT back in IDLE.
    task automatic run_stream(input vec_t v, input string tag);
        int   ones  = 0;
        int   proto = 0;
        int   bits  = 0;
        int   lf    = 0;
        int   ndone = 0;
        logic eb;
        start_generation = 1'b1;
        binary_value     = v.val;
        seed_load        = v.ld;
        seed_value       = v.sd;
        if (v.ld) m = (v.sd == 16'h0000) ? 16'hACE1 : v.sd;
        for (int c = 0; c <= LEN + 1; c++) begin
            @(negedge clk);
            if (bit_valid !== (c < LEN)) proto++;
            if (busy !== (c <= LEN)) proto++;
            if (generation_done !== (c == LEN)) proto++;
            if (generation_done === 1'b1) ndone++;
            if (c >= LEN && bitstream !== 1'b0) proto++;
            if (c < LEN) begin
                eb = (v.val == 16'hFFFF) || (m < v.val);
                m  = model_step(m);
                if (bitstream !== eb) bits++;
                if (bitstream === 1'b1) ones++;
                if (dut.u_lfsr.state !== m) lf++;
            end
            if (v.chk && c == 0)
                chk({tag, " lfsr_1"}, 32'(dut.u_lfsr.state), 32'hB400);
            if (v.chk && c == 1)
                chk({tag, " lfsr_2"}, 32'(dut.u_lfsr.state), 32'h5A00);
            start_generation = v.hold && (c < LEN - 2);
            seed_load        = (c == v.pulse);
            seed_value       = 16'h1234;
        end
        chk_rng({tag, " ones"}, ones, v.lo, v.hi);
        chk({tag, " protocol_errs"}, 32'(proto), 32'd0);
        chk({tag, " bit_errs"}, 32'(bits), 32'd0);
        chk({tag, " lfsr_errs"}, 32'(lf), 32'd0);
        chk({tag, " done_pulses"}, 32'(ndone), 32'd1);
    endtask

    initial begin
        int nd;
        tbl[0] = '{1'b0, 16'h0000, 16'h8000, 480, 544, 1'b0, -1, 1'b1};
        tbl[1] = '{1'b0, 16'h0000, 16'h0000, 0, 0, 1'b0, -1, 1'b0};
        tbl[2] = '{1'b0, 16'h0000, 16'hFFFF, LEN, LEN, 1'b0, LEN, 1'b0};
        tbl[3] = '{1'b0, 16'h0000, 16'h4000, 192, 320, 1'b1, 500, 1'b0};
        tbl[4] = '{1'b1, 16'h0000, 16'hC000, 704, 832, 1'b0, -1, 1'b0};
        tbl[5] = '{1'b1, 16'h5555, 16'h0001, 0, 8, 1'b0, -1, 1'b0};

        rst_n            = 1'b0;
        start_generation = 1'b0;
        binary_value     = 16'h0000;
        seed_load        = 1'b0;
        seed_value       = 16'h0000;
        repeat (3) @(negedge clk);
        chk("rst bit_valid", 32'(bit_valid), 32'd0);
        chk("rst bitstream", 32'(bitstream), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(generation_done), 32'd0);
        chk("rst lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        rst_n = 1'b1;

        // Zero seed falls back to the default seed
        seed_load  = 1'b1;
        seed_value = 16'h0000;
        @(negedge clk);
        chk("seed0 lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        seed_value = 16'h0001;
        @(negedge clk);
        seed_load = 1'b0;
        chk("seed1 lfsr", 32'(dut.u_lfsr.state), 32'h0001);
        chk("seed1 busy", 32'(busy), 32'd0);
        m = 16'h0001;

        // Rows run back to back: each start lands one cycle after done
        for (int i = 0; i < 6; i++) begin
            run_stream(tbl[i], $sformatf("row%0d", i));
        end

        // Reset during bit 300 of a stream
        start_generation = 1'b1;
        binary_value     = 16'h8000;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            start_generation = 1'b0;
        end
        chk("pre_abort valid", 32'(bit_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("abort valid", 32'(bit_valid), 32'd0);
        chk("abort bitstream", 32'(bitstream), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(generation_done), 32'd0);
        chk("abort lfsr", 32'(dut.u_lfsr.state), 32'hACE1);
        nd = 0;
        repeat (3) begin
            @(negedge clk);
            if (generation_done !== 1'b0) nd++;
        end
        rst_n = 1'b1;
        @(negedge clk);
        if (generation_done !== 1'b0) nd++;
        chk("abort no_done", 32'(nd), 32'd0);
        m = 16'hACE1;
        run_stream('{1'b0, 16'h0000, 16'h8000, 448, 576, 1'b0, -1, 1'b0},
                   "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
